// File: rtl/trig_tagger.sv
// -----------------------------------------------------------------------------
// trig_tagger
//   Builds timestamped TRIG/BEGIN/END records from the trigger stage pulses and
//   queues them in a small show-ahead FIFO for the readout sequencer.
//   The trigpulse that opens a long cycle pulse is filtered out. To do this,
//   each trigger is held pending for HOLD clocks. It is discarded if cycleend
//   arrives before it is committed.
//
// Ports
//   clk        in   160 MHz clock
//   rst_n      in   asynchronous active-low reset
//   enable     in   recording enable; 0 forces IDLE and blocks writes
//   trigpulse  in   1-clk trigger pulse
//   cycleend   in   1-clk spill-end pulse
//   cyclebegin in   1-clk spill-begin pulse
//   rd_ready   in   consumer accepts head record
//   rd_valid   out  FIFO non-empty
//   rd_data    out  {type[1:0], num[CNTW-1:0], ts[TSW-1:0]}; 00 TRIG, 01 BEGIN, 10 END
//   lost       out  records dropped on FIFO full (saturating)
// -----------------------------------------------------------------------------
module trig_tagger #(
    parameter int TSW    = 32,
    parameter int CNTW   = 16,
    parameter int HOLD   = 200,
    parameter int DEPTHL = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   trigpulse,
    input  logic                   cycleend,
    input  logic                   cyclebegin,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [2+CNTW+TSW-1:0]  rd_data,
    output logic [15:0]            lost
);
    localparam int RW    = 2 + CNTW + TSW;
    localparam int DEPTH = 1 << DEPTHL;
    localparam int AW    = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPILL = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [1:0] TY_TRIG  = 2'b00;
    localparam logic [1:0] TY_BEGIN = 2'b01;
    localparam logic [1:0] TY_END   = 2'b10;

    logic [1:0]        state_q,   state_d;
    logic [TSW-1:0]    ts_q,      ts_d;
    logic [CNTW-1:0]   trigcnt_q, trigcnt_d;
    logic [CNTW-1:0]   cycnum_q,  cycnum_d;
    logic              pend_q,    pend_d;
    logic [TSW-1:0]    pend_ts_q, pend_ts_d;
    logic [AW-1:0]     age_q,     age_d;
    logic [RW-1:0]     mem_q [DEPTH];
    logic [RW-1:0]     mem_d [DEPTH];
    logic [DEPTHL-1:0] wr_ptr_q,  wr_ptr_d;
    logic [DEPTHL-1:0] rd_ptr_q,  rd_ptr_d;
    logic [DEPTHL:0]   count_q,   count_d;
    logic [15:0]       lost_q,    lost_d;

    logic          wr_en;
    logic [RW-1:0] wr_rec;
    logic          pop, push, full;

    // Event recording FSM and pending-trigger holding register
    always_comb begin
        state_d   = state_q;
        ts_d      = ts_q + 1'b1;
        trigcnt_d = trigcnt_q;
        cycnum_d  = cycnum_q;
        pend_d    = pend_q;
        pend_ts_d = pend_ts_q;
        age_d     = pend_q ? age_q + 1'b1 : age_q;
        wr_en     = 1'b0;
        wr_rec    = '0;

        if (!enable) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else if (state_q == ST_SPILL) begin
            if (cycleend) begin
                // The still-pending trigger was the leading edge of the cycle pulse.
                pend_d  = 1'b0;
                wr_en   = 1'b1;
                wr_rec  = {TY_END, trigcnt_q, ts_q};
                state_d = ST_GAP;
            end else if (trigpulse) begin
                if (pend_q) begin
                    wr_en     = 1'b1;
                    wr_rec    = {TY_TRIG, trigcnt_q, pend_ts_q};
                    trigcnt_d = trigcnt_q + 1'b1;
                end
                pend_d    = 1'b1;
                pend_ts_d = ts_q;
                age_d     = '0;
            end else if (pend_q && age_q == AW'(HOLD - 1)) begin
                wr_en     = 1'b1;
                wr_rec    = {TY_TRIG, trigcnt_q, pend_ts_q};
                trigcnt_d = trigcnt_q + 1'b1;
                pend_d    = 1'b0;
            end
        end else if (cyclebegin) begin
            wr_en     = 1'b1;
            wr_rec    = {TY_BEGIN, cycnum_q, ts_q};
            cycnum_d  = cycnum_q + 1'b1;
            trigcnt_d = '0;
            state_d   = ST_SPILL;
        end
    end

    // Show-ahead FIFO; a write into a full FIFO still lands if the head pops this clk
    always_comb begin
        full     = (count_q == (DEPTHL+1)'(DEPTH));
        pop      = (count_q != '0) && rd_ready;
        push     = wr_en && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        lost_d   = lost_q;

        if (push) begin
            mem_d[wr_ptr_q] = wr_rec;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (wr_en && !push && lost_q != 16'hFFFF) begin
            lost_d = lost_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ts_q      <= '0;
            trigcnt_q <= '0;
            cycnum_q  <= '0;
            pend_q    <= 1'b0;
            pend_ts_q <= '0;
            age_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            lost_q    <= '0;
        end else begin
            state_q   <= state_d;
            ts_q      <= ts_d;
            trigcnt_q <= trigcnt_d;
            cycnum_q  <= cycnum_d;
            pend_q    <= pend_d;
            pend_ts_q <= pend_ts_d;
            age_q     <= age_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            lost_q    <= lost_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign lost     = lost_q;

endmodule

// File: tb/tb_trig_tagger.sv
module tb_trig_tagger;
    localparam int TSW   = 32;
    localparam int CNTW  = 16;
    localparam int HOLD  = 200;
    localparam int DEPTH = 4;
    localparam int RW    = 2 + CNTW + TSW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          trigpulse = 1'b0;
    logic          cycleend = 1'b0;
    logic          cyclebegin = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic [15:0]   lost;

    int total = 0;
    int bad   = 0;

    trig_tagger #(.TSW(TSW), .CNTW(CNTW), .HOLD(HOLD), .DEPTHL(2)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trigpulse(trigpulse),
        .cycleend(cycleend), .cyclebegin(cyclebegin), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .lost(lost)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // phase: 0 = no spill seen yet, 1 = inside spill, 2 = between spills
    int            m_phase;
    longint        m_now;          // clocks since reset release == timestamp
    logic [15:0]   m_trigcnt, m_cycnum, m_lost;
    bit            m_pend;
    longint        m_pend_at;      // clock in which the pending trigger arrived
    logic [RW-1:0] m_q[$];

    function automatic logic [RW-1:0] rec(input logic [1:0] ty, input logic [15:0] n, input longint t);
        logic [31:0] t32;
        t32 = t[31:0];
        return {ty, n, t32};
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_now = 0; m_trigcnt = 0; m_cycnum = 0; m_lost = 0;
        m_pend = 0; m_pend_at = 0;
        m_q.delete();
    endfunction

    function automatic void model_step(input bit en, cb, ce, tp, rdy);
        logic [RW-1:0] w, junk;
        bit wv;
        wv = 0; w = '0;
        if (!en) begin
            m_phase = 0; m_pend = 0;
        end else if (m_phase == 1) begin
            if (ce) begin
                m_pend = 0; wv = 1; w = rec(2'b10, m_trigcnt, m_now); m_phase = 2;
            end else if (tp) begin
                if (m_pend) begin
                    wv = 1; w = rec(2'b00, m_trigcnt, m_pend_at); m_trigcnt++;
                end
                m_pend = 1; m_pend_at = m_now;
            end else if (m_pend && m_now == m_pend_at + HOLD) begin
                wv = 1; w = rec(2'b00, m_trigcnt, m_pend_at); m_trigcnt++; m_pend = 0;
            end
        end else if (cb) begin
            wv = 1; w = rec(2'b01, m_cycnum, m_now); m_cycnum++; m_trigcnt = 0; m_phase = 1;
        end
        if (rdy && m_q.size() > 0) junk = m_q.pop_front();
        if (wv) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else if (m_lost != 16'hFFFF) m_lost++;
        end
        m_now++;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model_valid", 64'(rd_valid), 64'(m_q.size() > 0));
        check("model_lost", 64'(lost), 64'(m_lost));
        if (m_q.size() > 0) check("model_data", 64'(rd_data), 64'(m_q[0]));
    endtask

    // Inputs driven at the falling edge, DUT samples on rising edge, outputs checked at next falling edge
    task automatic cyc(input bit en, cb, ce, tp, rdy);
        enable = en; cyclebegin = cb; cycleend = ce; trigpulse = tp; rd_ready = rdy;
        @(posedge clk);
        model_step(en, cb, ce, tp, rdy);
        @(negedge clk);
        enable = en; cyclebegin = 0; cycleend = 0; trigpulse = 0;
        check_model();
    endtask

    task automatic idle(input int n, input bit en, input bit rdy);
        for (int i = 0; i < n; i++) cyc(en, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; enable = 0; cyclebegin = 0; cycleend = 0; trigpulse = 0; rd_ready = 0;
        model_reset();
        #1;
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_lost", 64'(lost), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        bit         en, cb, ce, tp, rdy;
        bit         exp_valid;
        logic [1:0] exp_type;
        logic [15:0] exp_lost;
    } vec_t;

    vec_t tbl[10];

    initial begin
        longint t_a, t_b, t_d, t_e;
        int off;

        // FIFO fill/overflow/drain: six records with the reader stalled, then drain
        tbl = '{
            '{1,1,0,0,0, 1, 2'b01, 16'd0},
            '{1,0,1,0,0, 1, 2'b01, 16'd0},
            '{1,1,0,0,0, 1, 2'b01, 16'd0},
            '{1,0,1,0,0, 1, 2'b01, 16'd0},
            '{1,1,0,0,0, 1, 2'b01, 16'd1},
            '{1,0,1,0,0, 1, 2'b01, 16'd2},
            '{1,0,0,0,1, 1, 2'b10, 16'd2},
            '{1,0,0,0,1, 1, 2'b01, 16'd2},
            '{1,0,0,0,1, 1, 2'b10, 16'd2},
            '{1,0,0,0,1, 0, 2'b00, 16'd2}
        };

        do_reset();

        // BEGIN record visible one clk after cyclebegin, carrying cycnum 0
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("begin_valid", 64'(rd_valid), 64'd1);
        check("begin_data", 64'(rd_data), 64'({2'b01, 16'd0, 32'd1}));
        cyc(1, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 1);
        check("begin2_num", 64'(rd_data[RW-3 -: 16]), 64'd1);
        idle(3, 1, 1);

        // Table-driven FIFO overflow and drain
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].en, tbl[i].cb, tbl[i].ce, tbl[i].tp, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), 64'(rd_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_lost", i), 64'(lost), 64'(tbl[i].exp_lost));
            if (tbl[i].exp_valid) check($sformatf("tbl%0d_type", i), 64'(rd_data[RW-1 -: 2]), 64'(tbl[i].exp_type));
        end

        // Trigger numbering: commit on next trigger, then on hold expiry
        do_reset();
        cyc(1, 1, 0, 0, 1);
        idle(5, 1, 1);
        t_a = m_now; cyc(1, 0, 0, 1, 1);
        idle(9, 1, 1);
        check("trig_held", 64'(rd_valid), 64'd0);
        t_b = m_now; cyc(1, 0, 0, 1, 1);
        check("trig0", 64'(rd_data), 64'(rec(2'b00, 16'd0, t_a)));
        idle(9, 1, 1);
        t_d = m_now; cyc(1, 0, 0, 1, 1);
        check("trig1", 64'(rd_data), 64'(rec(2'b00, 16'd1, t_b)));
        idle(HOLD - 1, 1, 1);
        check("trig2_not_yet", 64'(rd_valid), 64'd0);
        idle(1, 1, 1);
        check("trig2_valid", 64'(rd_valid), 64'd1);
        check("trig2", 64'(rd_data), 64'(rec(2'b00, 16'd2, t_d)));

        // Cycle-pulse trigger filtered: cycleend 162 clk after trigpulse
        cyc(1, 0, 0, 1, 1);
        idle(161, 1, 1);
        check("filt_none", 64'(rd_valid), 64'd0);
        t_e = m_now; cyc(1, 0, 1, 0, 1);
        check("end_data", 64'(rd_data), 64'(rec(2'b10, 16'd3, t_e)));
        idle(HOLD + 2, 1, 1);
        check("end_no_trig", 64'(rd_valid), 64'd0);

        // Reset mid-operation with pending trigger and 3 queued records
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        do_reset();
        cyc(1, 0, 0, 1, 1);
        idle(HOLD + 2, 1, 1);
        check("post_rst_ignored", 64'(rd_valid), 64'd0);

        // enable drop during spill discards the pending trigger
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 0, 1, 1);
        idle(20, 1, 1);
        idle(5, 0, 1);
        cyc(1, 0, 0, 1, 1);
        idle(HOLD + 2, 1, 1);
        check("en_drop_none", 64'(rd_valid), 64'd0);

        // Randomized traffic against the model
        off = 0;
        for (int i = 0; i < 4000; i++) begin
            bit en_r, rdy_r;
            if ($urandom_range(499) == 0) off = $urandom_range(20, 5);
            en_r = (off == 0);
            if (off > 0) off--;
            rdy_r = ((i % 400) < 300) ? ($urandom_range(1) == 1) : 1'b0;
            cyc(en_r, $urandom_range(99) == 0, $urandom_range(299) == 0,
                $urandom_range(19) == 0, rdy_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
